// File: rtl/acc_result_reader.sv
// -----------------------------------------------------------------------------
// acc_result_reader
//
// Reads every row of the systolic-array Accumulator in address order and
// streams the rows to a downstream consumer over a valid/ready handshake.
// Reads are throttled so that the data already in flight always has a free
// slot in a small row buffer. This means backpressure never drops a row and
// never overwrites one.
//
// Ports
//   clk        : single clock for all state
//   rst        : synchronous, active-high reset
//   start      : one-cycle request to read out all Accumulator rows
//   test_mode  : Accumulator owned by BIST; aborts any transfer in progress
//   rd_en      : Accumulator read strobe
//   rd_addr    : Accumulator row address for the read
//   acc_data   : Accumulator row data, valid the cycle after rd_en
//   out_data   : one Accumulator row per beat
//   out_addr   : row index of the current beat
//   out_valid  : beat available
//   out_ready  : consumer accepts the beat
//   out_last   : beat carries the final row
//   busy       : a readout is in progress
//   done       : one-cycle pulse after the final row is accepted
// -----------------------------------------------------------------------------
module acc_result_reader #(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int PARTIAL_SUM_WIDTH = 19,
    parameter int ADDR_WIDTH        = $clog2(SYSTOLIC_SIZE),
    parameter int FIFO_DEPTH        = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       test_mode,
    output logic                                       rd_en,
    output logic [ADDR_WIDTH-1:0]                      rd_addr,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] acc_data,
    output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]                      out_addr,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       out_last,
    output logic                                       busy,
    output logic                                       done
);

    localparam int DW = SYSTOLIC_SIZE * PARTIAL_SUM_WIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough for fifo_count + inflight, which can reach FIFO_DEPTH + 1.
    localparam int CW = $clog2(FIFO_DEPTH + 2);

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    localparam logic [PW-1:0]         LAST_PTR = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Read pipeline: one row is in flight between rd_en and its buffer write.
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;

    // Row buffer
    logic [DW-1:0]         data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] tag_mem  [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic [CW-1:0] occupancy;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    // A row is pushed only where it has a slot. The read throttle below
    // guarantees this already, so the guard never drops a row in practice.
    assign push      = inflight & (~fifo_full | pop);

    // Slots that are committed once this cycle's pop has left the buffer.
    assign occupancy = fifo_count + CW'(inflight) - CW'(pop);

    // Outputs are gated with out_valid so they read as zero when the buffer is
    // empty, which avoids putting a reset on the storage itself.
    assign out_data = out_valid ? data_mem[rd_ptr] : '0;
    assign out_addr = out_valid ? tag_mem[rd_ptr]  : '0;
    assign out_last = out_valid & (tag_mem[rd_ptr] == LAST_ROW);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    // NOTE: next_state gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !test_mode) begin
                    next_state = READ;
                end
            end
            READ: begin
                if (test_mode) begin
                    next_state = IDLE;
                end else if (rd_en && (rd_addr == LAST_ROW)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (test_mode) begin
                    next_state = IDLE;
                end else if (pop && out_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        busy  = (state != IDLE);
        // Issue a read only if its row has a guaranteed slot. Reads stop at
        // once when BIST takes the Accumulator.
        rd_en = (state == READ) && !test_mode && (occupancy < CW'(FIFO_DEPTH));
    end

    // ---------------------------------------------------------------------
    // Read address, in-flight tracking, buffer pointers and done pulse
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || test_mode) begin
            // BIST takeover flushes the buffer and discards the in-flight row.
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            done          <= 1'b0;
        end else begin
            if (rd_en) begin
                // Wrap to row 0 after the last row, so the next readout
                // starts there.
                rd_addr <= (rd_addr == LAST_ROW) ? '0 : rd_addr + 1'b1;
            end
            inflight      <= rd_en;
            inflight_addr <= rd_addr;

            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            done <= (state == DRAIN) && pop && out_last;
        end
    end

    // NOTE: the row storage has no reset. Pointers and count are reset, and
    // the outputs are masked when the buffer is empty, so stale contents are
    // never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= acc_data;
            tag_mem[wr_ptr]  <= inflight_addr;
        end
    end

endmodule

// File: tb/tb_acc_result_reader.sv
// -----------------------------------------------------------------------------
// Testbench for acc_result_reader.
// The bench models the Accumulator as an array with one-cycle read latency.
// A reference model checks every cycle that rows come out in order and
// bit-exact, that read addresses increase, that committed slots never exceed
// the buffer depth, and that done follows the last accepted row.
// Directed sequences add literal, hand-derived timing and count expectations.
// -----------------------------------------------------------------------------
module tb_acc_result_reader;

    localparam int SS  = 8;
    localparam int PSW = 19;
    localparam int AW  = 3;
    localparam int FD  = 2;
    localparam int DW  = SS * PSW;

    localparam logic [DW-1:0] JUNK = {SS{19'h2A5A5}};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          test_mode;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] acc_data;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    acc_result_reader #(
        .SYSTOLIC_SIZE    (SS),
        .PARTIAL_SUM_WIDTH(PSW),
        .ADDR_WIDTH       (AW),
        .FIFO_DEPTH       (FD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .test_mode(test_mode),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .acc_data (acc_data),
        .out_data (out_data),
        .out_addr (out_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    // Accumulator model: data appears the cycle after rd_en, junk otherwise.
    logic [DW-1:0] acc_mem [SS];
    always @(posedge clk) acc_data <= rd_en ? acc_mem[rd_addr] : JUNK;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    bit   chk_en = 0;
    int   exp_row, exp_rd, occ, max_occ;
    bit   done_pending;
    bit   prev_stall;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic          prev_last;
    bit   pop_now, is_last;

    // ---------------- event log for directed checks ----------------
    int   rd_cnt, first_rd, last_rd, beat_cnt, first_vld, last_cyc, last_cnt, done_cnt, done_cyc;
    bit   busy_seen;
    logic [DW-1:0] last_data;

    task automatic model_reset();
        exp_row      = 0;
        exp_rd       = 0;
        occ          = 0;
        done_pending = 0;
        prev_stall   = 0;
    endtask

    task automatic clear_log();
        rd_cnt = 0; first_rd = -1; last_rd = -1; beat_cnt = 0; first_vld = -1;
        last_cyc = -1; last_cnt = 0; done_cnt = 0; done_cyc = -1; busy_seen = 0;
        max_occ = 0; last_data = '0;
    endtask

    // Compare process: outputs are sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_int("done_timing", int'(done), int'(done_pending));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1;

            if (rd_en) begin
                check_int("rd_addr_order", int'(rd_addr), exp_rd);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                rd_cnt++;
                exp_rd = (exp_rd + 1) % SS;
            end

            if (out_valid) begin
                check_int("beat_without_read", int'(occ > 0), 1);
                if (prev_stall) begin
                    check("stall_data_stable", out_data, prev_data);
                    check_int("stall_addr_stable", int'(out_addr), int'(prev_addr));
                    check_int("stall_last_stable", int'(out_last), int'(prev_last));
                end
                check_int("out_addr", int'(out_addr), exp_row);
                check("out_data", out_data, acc_mem[exp_row]);
                check_int("out_last", int'(out_last), int'(exp_row == SS - 1));
                if (first_vld < 0) first_vld = cyc;
            end

            pop_now = out_valid && out_ready;
            is_last = (exp_row == SS - 1);
            if (pop_now) begin
                beat_cnt++;
                if (is_last) begin
                    last_cnt++;
                    last_cyc  = cyc;
                    last_data = out_data;
                end
                exp_row = (exp_row + 1) % SS;
            end
            done_pending = pop_now && is_last;

            occ = occ + int'(rd_en) - int'(pop_now);
            check_int("occupancy_bound", int'(occ <= FD), 1);
            if (occ > max_occ) max_occ = occ;

            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
            prev_last  = out_last;
        end
    end

    // ---------------- stimulus helpers (drive at posedge + 1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit found = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (done) begin
                found = 1;
                break;
            end
        end
        check_int(name, int'(found), 1);
    endtask

    task automatic wait_rd(input string name, input int addr);
        bit found = 0;
        for (int i = 0; i < 100; i++) begin
            if (rd_en && int'(rd_addr) == addr) begin
                found = 1;
                break;
            end
            tick(1);
        end
        check_int(name, int'(found), 1);
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < SS; k++)
            for (int j = 0; j < SS; j++)
                acc_mem[k][j*PSW +: PSW] = PSW'(k);
    endtask

    task automatic fill_random();
        for (int k = 0; k < SS; k++)
            for (int j = 0; j < SS; j++)
                acc_mem[k][j*PSW +: PSW] = PSW'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int c0;
    bit found_t3;

    initial begin
        rst = 1'b1; start = 1'b0; test_mode = 1'b0; out_ready = 1'b1;
        fill_pattern();
        model_reset();
        clear_log();
        tick(3);

        // Reset state
        check_int("rst_rd_en", int'(rd_en), 0);
        check_int("rst_rd_addr", int'(rd_addr), 0);
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_out_last", int'(out_last), 0);
        check_int("rst_out_addr", int'(out_addr), 0);
        check("rst_out_data", out_data, '0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        rst = 1'b0;
        tick(1);
        chk_en = 1;

        // Zero-bubble readout, row k = k in every lane
        clear_log();
        c0 = cyc;
        pulse_start();
        wait_done("t1_done_seen");
        tick(2);
        check_int("t1_first_rd", first_rd - c0, 1);
        check_int("t1_last_rd", last_rd - c0, 8);
        check_int("t1_rd_cnt", rd_cnt, 8);
        check_int("t1_first_valid", first_vld - c0, 3);
        check_int("t1_last_cycle", last_cyc - c0, 10);
        check_int("t1_last_cnt", last_cnt, 1);
        check_int("t1_done_cycle", done_cyc - c0, 11);
        check_int("t1_done_cnt", done_cnt, 1);
        check_int("t1_beats", beat_cnt, 8);
        check("t1_row7_literal", last_data, {SS{19'd7}});

        // Consumer stalled for 10 cycles after start
        fill_random();
        out_ready = 1'b0;
        clear_log();
        pulse_start();
        tick(9);
        check_int("t2_reads_while_stalled", rd_cnt, FD);
        check_int("t2_rd_en_low", int'(rd_en), 0);
        check_int("t2_valid", int'(out_valid), 1);
        check_int("t2_head_addr", int'(out_addr), 0);
        check("t2_head_data", out_data, acc_mem[0]);
        out_ready = 1'b1;
        wait_done("t2_done_seen");
        tick(2);
        check_int("t2_beats", beat_cnt, 8);
        check_int("t2_rd_cnt", rd_cnt, 8);
        check_int("t2_done_cnt", done_cnt, 1);

        // Toggling ready
        fill_random();
        clear_log();
        pulse_start();
        found_t3 = 0;
        for (int i = 0; i < 100; i++) begin
            out_ready = ~out_ready;
            tick(1);
            if (done) begin
                found_t3 = 1;
                break;
            end
        end
        check_int("t3_done_seen", int'(found_t3), 1);
        out_ready = 1'b1;
        tick(2);
        check_int("t3_beats", beat_cnt, 8);
        check_int("t3_last_cnt", last_cnt, 1);
        check_int("t3_done_cnt", done_cnt, 1);
        check_int("t3_max_occ", int'(max_occ <= FD), 1);

        // Start ignored in test mode
        test_mode = 1'b1;
        clear_log();
        pulse_start();
        tick(5);
        check_int("t4_no_reads", rd_cnt, 0);
        check_int("t4_never_busy", int'(busy_seen), 0);
        test_mode = 1'b0;
        tick(1);

        // BIST takeover at row 4
        clear_log();
        pulse_start();
        wait_rd("t4b_reach_row4", 4);
        test_mode = 1'b1;
        tick(1);
        model_reset();
        check_int("t4b_idle", int'(busy), 0);
        check_int("t4b_flushed", int'(out_valid), 0);
        check_int("t4b_rd_en", int'(rd_en), 0);
        tick(3);
        test_mode = 1'b0;
        tick(5);
        check_int("t4b_no_done", done_cnt, 0);
        check_int("t4b_still_empty", int'(out_valid), 0);

        // Reset at row 5, then a fresh readout
        fill_random();
        clear_log();
        pulse_start();
        wait_rd("t5_reach_row5", 5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        check_int("t5_idle", int'(busy), 0);
        check_int("t5_empty", int'(out_valid), 0);
        check_int("t5_no_done", int'(done), 0);
        clear_log();
        pulse_start();
        wait_done("t5_done_seen");
        tick(2);
        check_int("t5_done_cnt", done_cnt, 1);
        check_int("t5_beats", beat_cnt, 8);
        check_int("t5_rd_cnt", rd_cnt, 8);

        // Start while busy ignored, start on done cycle accepted
        fill_random();
        clear_log();
        pulse_start();
        tick(3);
        pulse_start();
        wait_done("t6_done_seen");
        check_int("t6_rd_cnt_first", rd_cnt, 8);
        start = 1'b1;
        c0 = cyc;
        tick(1);
        start = 1'b0;
        clear_log();
        wait_done("t6_second_done_seen");
        tick(2);
        check_int("t6_restart_rd", first_rd - c0, 1);
        check_int("t6_rd_cnt_second", rd_cnt, 8);
        check_int("t6_beats_second", beat_cnt, 8);
        check_int("t6_done_cnt_second", done_cnt, 1);

        chk_en = 0;
        tick(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
